// File: rtl/gate_sequencer.sv
// Gated-count sequencer for the frequency meter: clear, gate, settle, latch,
// then hand the latched count to the readout side over a valid/ack handshake.
module gate_sequencer #(
  parameter int GATE_CYCLES   = 100_000_000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [CNT_W-1:0] meas_count,
  input  logic             meas_ovf,
  input  logic             result_ack,
  output logic             cnt_clear,
  output logic             gate_en,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             result_ovf,
  output logic             overrun,
  output logic             busy
);

  localparam int MAX_CYCLES = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  // The timer only ever holds a load value of MAX_CYCLES-1.
  localparam int TMR_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               cnt_clear_q, cnt_clear_d;
  logic               gate_en_q, gate_en_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               result_ovf_q, result_ovf_d;
  logic               overrun_q, overrun_d;
  logic               capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = CLEAR;
        end
        CLEAR: begin
          state_d = GATE;
          tmr_d   = GATE_LOAD;
        end
        GATE: begin
          if (tmr_q == '0) begin
            state_d = SETTLE;
            tmr_d   = SETTLE_LOAD;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        SETTLE: begin
          if (tmr_q == '0) state_d = LATCH;
          else             tmr_d   = tmr_q - TMR_W'(1);
        end
        LATCH: begin
          state_d = continuous ? CLEAR : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter controls come from the next state so they are glitch-free flops.
  always_comb begin
    cnt_clear_d    = (state_d == CLEAR);
    gate_en_d      = (state_d == GATE);
    capture        = (state_q == LATCH) && !abort;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    result_ovf_d   = result_ovf_q;
    overrun_d      = overrun_q;
    // A capture outranks a same-cycle ack: the fresh result must not be lost.
    if (capture) begin
      result_d       = meas_count;
      result_ovf_d   = meas_ovf;
      result_valid_d = 1'b1;
      if (result_valid_q && !result_ack) overrun_d = 1'b1;
    end else if (result_ack && result_valid_q) begin
      result_valid_d = 1'b0;
      overrun_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_clear_q    <= 1'b0;
      gate_en_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_ovf_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_clear_q    <= cnt_clear_d;
      gate_en_q      <= gate_en_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_ovf_q   <= result_ovf_d;
      overrun_q      <= overrun_d;
    end
  end

  assign cnt_clear    = cnt_clear_q;
  assign gate_en      = gate_en_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_ovf   = result_ovf_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer: directed scenarios plus random
// stimulus, all compared against a measurement-timeline reference model.
module tb_gate_sequencer;

  localparam int G = 10;
  localparam int S = 2;
  localparam int W = 32;
  localparam int L = G + S + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] meas_count = '0;
  logic         meas_ovf = 1'b0;
  logic         result_ack = 1'b0;
  logic         cnt_clear, gate_en, result_valid, result_ovf, overrun, busy;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  gate_sequencer #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .meas_count(meas_count), .meas_ovf(meas_ovf), .result_ack(result_ack),
    .cnt_clear(cnt_clear), .gate_en(gate_en), .result(result),
    .result_valid(result_valid), .result_ovf(result_ovf), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: m_t is the position within a measurement (0 idle, 1 clear,
  // 2..G+1 gate open, then settle, L latch).
  int           m_t = 0;
  logic [W-1:0] m_result = '0;
  logic         m_valid = 1'b0;
  logic         m_rovf = 1'b0;
  logic         m_overrun = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t       <= 0;
      m_result  <= '0;
      m_valid   <= 1'b0;
      m_rovf    <= 1'b0;
      m_overrun <= 1'b0;
    end else begin
      if (m_t == L && !abort) begin
        if (m_valid && !result_ack) m_overrun <= 1'b1;
        m_result <= meas_count;
        m_rovf   <= meas_ovf;
        m_valid  <= 1'b1;
      end else if (result_ack && m_valid) begin
        m_valid   <= 1'b0;
        m_overrun <= 1'b0;
      end
      if (m_t == 0)           m_t <= start ? 1 : 0;
      else if (abort)         m_t <= 0;
      else if (m_t == L)      m_t <= continuous ? 1 : 0;
      else                    m_t <= m_t + 1;
    end
  end

  logic [W+5:0] exp_vec, obs_vec;
  assign exp_vec = {(m_t == 1), (m_t >= 2 && m_t <= G + 1), (m_t != 0),
                    m_valid, m_rovf, m_overrun, m_result};
  assign obs_vec = {cnt_clear, gate_en, busy, result_valid, result_ovf, overrun, result};

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h expected=0", obs_vec);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL reset_release actual=%h expected=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_single_shot();
    meas_count = 123;
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if (cnt_clear !== (c == 1) || gate_en !== (c >= 2 && c <= 11)) begin
        failures++;
        $display("FAIL single_timing cycle=%0d actual clr=%b gate=%b", c, cnt_clear, gate_en);
      end
      if (c == 15) begin
        checks++;
        if (result !== 123 || result_valid !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL single_result actual res=%0d v=%b busy=%b expected 123/1/0",
                   result, result_valid, busy);
        end
      end
      if (c == 17) begin
        checks++;
        if (result_valid !== 1'b0) begin
          failures++;
          $display("FAIL single_ack actual valid=%b expected 0", result_valid);
        end
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_single cycle=%0d actual=%h expected=%h", c, obs_vec, exp_vec);
      end
      result_ack = (c == 16);
    end
    result_ack = 1'b0;
  endtask

  task automatic test_continuous();
    continuous = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 73; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if (cnt_clear !== (c <= 57 && (c - 1) % 14 == 0)) begin
        failures++;
        $display("FAIL cont_clear cycle=%0d actual=%b", c, cnt_clear);
      end
      if (c == 15 || c == 29 || c == 43) begin
        checks++;
        if (result_valid !== 1'b1 || overrun !== 1'b0 || result !== W'(1000 + c - 1)) begin
          failures++;
          $display("FAIL cont_ack_on_latch cycle=%0d actual v=%b ovr=%b res=%0d expected 1/0/%0d",
                   c, result_valid, overrun, result, 1000 + c - 1);
        end
      end
      if (c == 57 || c == 71) begin
        checks++;
        if (overrun !== 1'b1 || result !== W'(1000 + c - 1) || result_valid !== 1'b1) begin
          failures++;
          $display("FAIL cont_overrun cycle=%0d actual ovr=%b res=%0d v=%b expected 1/%0d/1",
                   c, overrun, result, result_valid, 1000 + c - 1);
        end
      end
      if (c == 72) begin
        checks++;
        if (result_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL cont_final_ack actual v=%b ovr=%b busy=%b expected 0/0/0",
                   result_valid, overrun, busy);
        end
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_cont cycle=%0d actual=%h expected=%h", c, obs_vec, exp_vec);
      end
      meas_count = W'(1000 + c);
      result_ack = (c <= 42 && c % 14 == 0) || (c == 71);
      if (c == 60) continuous = 1'b0;
    end
    result_ack = 1'b0;
  endtask

  task automatic test_abort();
    meas_count = 55;
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    meas_count = 77;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 7) begin
        abort = 1'b0;
        checks++;
        if (gate_en !== 1'b0 || busy !== 1'b0 || result !== 55 || result_valid !== 1'b1) begin
          failures++;
          $display("FAIL abort_gate actual gate=%b busy=%b res=%0d v=%b expected 0/0/55/1",
                   gate_en, busy, result, result_valid);
        end
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_abort cycle=%0d actual=%h expected=%h", c, obs_vec, exp_vec);
      end
      if (c == 6) abort = 1'b1;
    end
    abort = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt_clear !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle actual busy=%b clr=%b expected 0/0", busy, cnt_clear);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || cnt_clear !== 1'b1) begin
      failures++;
      $display("FAIL abort_with_start actual busy=%b clr=%b expected 1/1", busy, cnt_clear);
    end
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_abort_start cycle=%0d actual=%h expected=%h", c, obs_vec, exp_vec);
      end
      result_ack = (c == 15);
    end
    result_ack = 1'b0;
  endtask

  task automatic test_ovf_and_busy_start();
    meas_ovf = 1'b1;
    meas_count = 4242;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++;
      if (cnt_clear !== (c == 1)) begin
        failures++;
        $display("FAIL busy_start_clear cycle=%0d actual=%b", c, cnt_clear);
      end
      if (c == 15) begin
        checks++;
        if (result_ovf !== 1'b1 || result !== 4242) begin
          failures++;
          $display("FAIL ovf_capture actual ovf=%b res=%0d expected 1/4242", result_ovf, result);
        end
      end
      start = (c >= 3 && c <= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    meas_ovf = 1'b0;
  endtask

  task automatic test_reset_mid_settle();
    meas_count = 9;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL reset_mid_settle actual=%h expected=0", obs_vec);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL reset_recover cycle=%0d actual=%h expected=%h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_random cycle=%0d actual=%h expected=%h", c, obs_vec, exp_vec);
      end
      start      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) continuous = ~continuous;
      abort      = ($urandom_range(0, 63) == 0);
      result_ack = ($urandom_range(0, 2) == 0);
      meas_count = $urandom;
      meas_ovf   = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    result_ack = 1'b0;
    continuous = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_abort();
    test_ovf_and_busy_start();
    test_reset_mid_settle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
